pwm_flash_player: RTL and testbench
===================================

// Module: pwm_flash_player
// PURPOSE
//   Tiny Tapeout user tile that streams 8-bit audio/duty samples from an external SPI flash.
//   It plays each sample as one 256-clock PWM period.
//   The flash is on the bidirectional pins (CS/MOSI/MISO/SCK); the PWM output is on uio_out[7].
//   The top-level tile wrapper inverts the tile rst_n into rst.
// PARAMETERS
//   CMD_READ   8'h03   SPI flash read opcode sent after reset release
//   PWM_BITS   8       duty/counter width; PWM period = 2**PWM_BITS clocks
// PORTS
//   clk      in   1   system clock; all logic is on the rising edge
//   rst      in   1   asynchronous, active-high reset
//   ena      in   1   tile select; ignored (design always runs)
//   ui_in    in   8   start address high byte; flash start address = {ui_in,16'h0000}
//   uo_out   out  8   duty value currently being played
//   uio_in   in   8   bit2 = spi_miso; all other bits ignored
//   uio_out  out  8   bit0 spi_cs (active low), bit1 spi_mosi, bit3 spi_sck, bit7 pwm; others 0
//   uio_oe   out  8   constant 8'b1000_1011
// BEHAVIOUR
//   Reset (async): cs=1, sck=0, mosi=0, pwm=0, duty=0, uo_out=0, pwm counter=0, buffer empty.
//   SPI mode 0; SCK = clk/2 while a transfer is active:
//     - SCK is high for one clk and low for one clk; SCK idles low.
//     - MOSI changes only while SCK is low.
//     - MISO is sampled on the clk edge that drives SCK from high to low.
//   FSM: IDLE -> CMD -> DATA -> WAIT -> DATA ...
//     IDLE: first clk after reset release; latch ui_in as the address.
//     CMD: cs=0; shift 32 bits MSB first: CMD_READ then the 24-bit address (64 clks).
//     DATA: clock in 8 bits MSB first (16 clks), then write the byte to the sample buffer and mark it full.
//     WAIT: SCK held low, CS stays low; return to DATA when the buffer becomes empty.
//   CS is never raised after the command; the flash auto-increments and wraps at its end.
//   PWM: free-running PWM_BITS counter 0..255.
//     - pwm = (counter < duty) (registered).
//     - duty=0 -> pwm always low; duty=255 -> high 255 of 256 clks.
//   Duty update: on counter wrap 255->0, if the buffer is full, duty <= buffer and the buffer is marked empty.
//     - If the buffer is empty, the previous duty is repeated (underrun holds the value; no glitch).
//   Simultaneous wrap and byte completion on the same clk: duty takes the old buffer contents.
//     - The new byte is stored into the buffer, which stays full.
//   uo_out = duty.
//   ui_in changes after IDLE are ignored until the next reset.
//   Reset mid-transfer aborts immediately: CS is raised and the full sequence restarts from IDLE.
// STRUCTURE
//   Shared package: CMD_READ, FSM state enum (IDLE/CMD/DATA/WAIT), pin index constants (CS=0, MOSI=1, MISO=2, SCK=3, PWM=7).
//   One natural sub-module: pwm_gen (counter, duty register, compare, wrap strobe, buffer load).
//   The SPI reader FSM lives in the top module.
// TESTING
//   1) Reset then release with ui_in=8'h12:
//      - cs falls; MOSI bits on SCK rises = 8'h03,8'h12,8'h00,8'h00.
//      - Exactly 32 SCK pulses before data; uio_oe==8'h8B throughout.
//   2) Flash model returns 8'h80:
//      - In the period after the buffer is loaded, pwm is high for exactly 128 of 256 clks.
//      - uo_out==8'h80.
//   3) Bytes 8'h00 then 8'hFF: pwm never high for the first period, then high 255/256 clks; no SCK while buffer is full.
//   4) Byte sequence 8'h10,8'h20,8'h30: each period shows duty 16, 32, 48 in order; CS stays low the whole time.
//   5) Assert rst mid-command (after 10 SCK pulses):
//      - Outputs return to reset values asynchronously.
//      - After release, the command restarts from 8'h03.
//   6) Slow-down check (buffer never refilled in model, MISO stuck 1): duty settles at 8'hFF and repeats each period; pwm stays periodic.

Source files
------------

// File: rtl/pwm_flash_player_pkg.sv
// Shared constants for the PWM flash player: SPI opcode, PWM width, FSM states, pin map.
package pwm_flash_player_pkg;

   localparam logic [7:0]  CMD_READ = 8'h03;
   localparam int unsigned PWM_BITS = 8;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCmd  = 2'd1;
   localparam logic [1:0] StData = 2'd2;
   localparam logic [1:0] StWait = 2'd3;

   localparam int unsigned PinCs   = 0;
   localparam int unsigned PinMosi = 1;
   localparam int unsigned PinMiso = 2;
   localparam int unsigned PinSck  = 3;
   localparam int unsigned PinPwm  = 7;

   localparam logic [7:0] UIO_OE = 8'b1000_1011;

endpackage

// File: rtl/pwm_flash_player_pwm_gen.sv
// Free-running PWM generator with a one-entry sample buffer reloaded into duty on counter wrap.
module pwm_flash_player_pwm_gen
   import pwm_flash_player_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [PWM_BITS-1:0] byte_i,
   output logic                buf_full_o,
   output logic [PWM_BITS-1:0] duty_o,
   output logic                pwm_o
);

   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] buf_q, buf_d;
   logic                full_q, full_d;
   logic                pwm_q, pwm_d;
   logic                wrap;

   always_comb begin
      wrap   = (cnt_q == {PWM_BITS{1'b1}});
      cnt_d  = cnt_q + 1'b1;
      // An empty buffer at wrap repeats the previous duty.
      duty_d = (wrap && full_q) ? buf_q : duty_q;
      buf_d  = load_i ? byte_i : buf_q;
      // A byte landing on the wrap clock keeps the buffer full.
      full_d = load_i ? 1'b1 : (wrap ? 1'b0 : full_q);
      // Compare against next-state values so pwm_o aligns with the visible counter.
      pwm_d  = (cnt_d < duty_d);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         duty_q <= '0;
         buf_q  <= '0;
         full_q <= 1'b0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         buf_q  <= buf_d;
         full_q <= full_d;
         pwm_q  <= pwm_d;
      end
   end

   assign buf_full_o = full_q;
   assign duty_o     = duty_q;
   assign pwm_o      = pwm_q;

endmodule

// File: rtl/pwm_flash_player.sv
// Tiny Tapeout tile: issues one SPI flash READ, then streams bytes into a PWM output.
module pwm_flash_player
   import pwm_flash_player_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [1:0]  state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [7:0]  rx_q, rx_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        cs_q, cs_d;
   logic        load;
   logic        buf_full;
   logic        pwm;
   logic [7:0]  duty;
   logic        miso;
   logic        unused_in;

   assign miso      = uio_in[PinMiso];
   assign unused_in = ^{ena, uio_in[7:3], uio_in[1:0]};

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      load      = 1'b0;
      case (state_q)
         StIdle: begin
            shift_d   = {CMD_READ, ui_in, 16'h0000};
            mosi_d    = CMD_READ[7];
            cs_d      = 1'b0;
            bit_cnt_d = '0;
            state_d   = StCmd;
         end
         StCmd: begin
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               // Falling SCK edge: present the next bit while SCK is low.
               sck_d     = 1'b0;
               shift_d   = {shift_q[30:0], 1'b0};
               mosi_d    = shift_q[30];
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd31) begin
                  mosi_d    = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = StData;
               end
            end
         end
         StData: begin
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               sck_d     = 1'b0;
               rx_d      = {rx_q[6:0], miso};
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd7) begin
                  load      = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = StWait;
               end
            end
         end
         StWait: begin
            if (!buf_full) begin
               state_d = StData;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
      end
   end

   pwm_flash_player_pwm_gen u_pwm_gen (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load),
      .byte_i     ({rx_q[6:0], miso}),
      .buf_full_o (buf_full),
      .duty_o     (duty),
      .pwm_o      (pwm)
   );

   always_comb begin
      uio_out          = 8'h00;
      uio_out[PinCs]   = cs_q;
      uio_out[PinMosi] = mosi_q;
      uio_out[PinSck]  = sck_q;
      uio_out[PinPwm]  = pwm;
   end

   assign uio_oe = UIO_OE;
   assign uo_out = duty;

endmodule

// File: tb/tb_pwm_flash_player.sv
// Directed bench for pwm_flash_player with a behavioural SPI flash model.
module tb_pwm_flash_player;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;

   // Flash model state
   logic [7:0]  mem [8];
   bit          stuck = 1'b0;
   int          pulses = 0;
   logic [31:0] cmd_word = '0;
   logic        miso = 1'b0;
   int          cs_rises = 0;
   logic        cs_prev = 1'b1;
   int          pin_bad = 0;

   always #5 clk = ~clk;

   assign uio_in = {5'b00000, miso, 2'b00};

   pwm_flash_player dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // SCK is high for exactly one clk, so a high level at negedge marks one pulse.
   always @(negedge clk) begin
      int         idx;
      int         bi;
      logic [7:0] dbyte;
      if (rst || uio_out[0]) begin
         pulses   = 0;
         cmd_word = '0;
         miso     = 1'b0;
      end else if (uio_out[3]) begin
         if (pulses < 32) begin
            cmd_word = {cmd_word[30:0], uio_out[1]};
         end else begin
            idx   = pulses - 32;
            bi    = idx / 8;
            dbyte = stuck ? 8'hFF : ((bi < 8) ? mem[bi[2:0]] : 8'h00);
            miso  = dbyte[3'(7 - (idx % 8))];
         end
         pulses++;
      end
      if (!rst && !cs_prev && uio_out[0]) cs_rises++;
      cs_prev = uio_out[0];
      if (uio_oe !== 8'h8B || uio_out[6:4] !== 3'b000 || uio_out[2] !== 1'b0) pin_bad++;
   end

   task automatic do_reset(input logic [7:0] addr);
      rst   = 1'b1;
      ui_in = addr;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_pulses(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         if (pulses >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Counts pwm-high clocks over one 256-clock period.
   task automatic period_high(output int high);
      high = 0;
      repeat (256) begin
         @(negedge clk);
         if (uio_out[7]) high++;
      end
   endtask

   // After do_reset, the duty from the first byte plays on clocks 256..511.
   task automatic skip_to_first_period();
      repeat (255) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (uio_out !== 8'h01) begin
         errors++;
         $display("FAIL reset_uio_out: got %h want 01", uio_out);
      end
      checks++;
      if (uo_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_uo_out: got %h want 00", uo_out);
      end
      checks++;
      if (uio_oe !== 8'h8B) begin
         errors++;
         $display("FAIL reset_uio_oe: got %h want 8b", uio_oe);
      end
   endtask

   task automatic test_cmd();
      bit ok;
      do_reset(8'h12);
      wait_pulses(32, ok);
      ui_in = 8'hFF;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL cmd_timeout: pulses %0d want 32", pulses);
      end
      checks++;
      if (cmd_word !== 32'h0312_0000) begin
         errors++;
         $display("FAIL cmd_word: got %h want 03120000", cmd_word);
      end
      checks++;
      if (uio_out[0] !== 1'b0) begin
         errors++;
         $display("FAIL cmd_cs_low: got %b want 0", uio_out[0]);
      end
   endtask

   task automatic test_duty_half();
      int high;
      mem[0] = 8'h80;
      mem[1] = 8'h80;
      do_reset(8'h00);
      skip_to_first_period();
      period_high(high);
      checks++;
      if (high !== 128) begin
         errors++;
         $display("FAIL half_high: got %0d want 128", high);
      end
      checks++;
      if (uo_out !== 8'h80) begin
         errors++;
         $display("FAIL half_uo_out: got %h want 80", uo_out);
      end
   endtask

   task automatic test_extremes();
      int high;
      mem[0] = 8'h00;
      mem[1] = 8'hFF;
      mem[2] = 8'hFF;
      do_reset(8'h01);
      skip_to_first_period();
      period_high(high);
      #1;
      checks++;
      if (high !== 0) begin
         errors++;
         $display("FAIL zero_high: got %0d want 0", high);
      end
      checks++;
      if (pulses !== 48) begin
         errors++;
         $display("FAIL zero_pulses: got %0d want 48", pulses);
      end
      period_high(high);
      #1;
      checks++;
      if (high !== 255) begin
         errors++;
         $display("FAIL full_high: got %0d want 255", high);
      end
      checks++;
      if (uo_out !== 8'hFF) begin
         errors++;
         $display("FAIL full_uo_out: got %h want ff", uo_out);
      end
      checks++;
      if (pulses !== 56) begin
         errors++;
         $display("FAIL full_pulses: got %0d want 56", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int         high;
      int         want_high [3];
      logic [7:0] want_duty [3];
      want_high = '{16, 32, 48};
      want_duty = '{8'h10, 8'h20, 8'h30};
      mem[0] = 8'h10;
      mem[1] = 8'h20;
      mem[2] = 8'h30;
      mem[3] = 8'h40;
      do_reset(8'h02);
      cs_rises = 0;
      skip_to_first_period();
      for (int p = 0; p < 3; p++) begin
         period_high(high);
         checks++;
         if (high !== want_high[p]) begin
            errors++;
            $display("FAIL seq_high[%0d]: got %0d want %0d", p, high, want_high[p]);
         end
         checks++;
         if (uo_out !== want_duty[p]) begin
            errors++;
            $display("FAIL seq_duty[%0d]: got %h want %h", p, uo_out, want_duty[p]);
         end
      end
      checks++;
      if (cs_rises !== 0 || uio_out[0] !== 1'b0) begin
         errors++;
         $display("FAIL seq_cs_low: rises %0d cs %b want 0 0", cs_rises, uio_out[0]);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      do_reset(8'h55);
      wait_pulses(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midrst_timeout: pulses %0d want 10", pulses);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (uio_out !== 8'h01) begin
         errors++;
         $display("FAIL midrst_uio_out: got %h want 01", uio_out);
      end
      checks++;
      if (uo_out !== 8'h00) begin
         errors++;
         $display("FAIL midrst_uo_out: got %h want 00", uo_out);
      end
      do_reset(8'hA5);
      wait_pulses(32, ok);
      checks++;
      if (!ok || cmd_word !== 32'h03A5_0000) begin
         errors++;
         $display("FAIL midrst_cmd: got %h ok %0d want 03a50000", cmd_word, ok);
      end
   endtask

   task automatic test_stuck_miso();
      int high;
      stuck = 1'b1;
      do_reset(8'h03);
      skip_to_first_period();
      for (int p = 0; p < 2; p++) begin
         period_high(high);
         checks++;
         if (high !== 255) begin
            errors++;
            $display("FAIL stuck_high[%0d]: got %0d want 255", p, high);
         end
         checks++;
         if (uo_out !== 8'hFF) begin
            errors++;
            $display("FAIL stuck_duty[%0d]: got %h want ff", p, uo_out);
         end
      end
      stuck = 1'b0;
   endtask

   task automatic test_pins();
      checks++;
      if (pin_bad !== 0) begin
         errors++;
         $display("FAIL pin_static: got %0d bad samples want 0", pin_bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      test_reset();
      test_cmd();
      test_duty_half();
      test_extremes();
      test_back_to_back();
      test_mid_reset();
      test_stuck_miso();
      test_pins();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
